switch_conditioner: RTL and testbench

Input conditioning stage sitting directly upstream of the picoMips core. It synchronises the raw slide-switch bus, debounces the SW[8] handshake switch, and freezes the data switches SW[7:0] while a handshake is in progress. The picoMips HEI/LSW instructions therefore see exactly one clean level change per physical toggle and a stable operand. Its SW_clean output drives the core's SW[8:0]; SW[9] (nReset) bypasses this block.

---
 rtl/switch_conditioner.sv | 97 +++++++++
 tb/tb_switch_conditioner.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/switch_conditioner.sv
// Switch conditioner in front of picoMips. Synchronises SW[8:0], debounces the SW[8] handshake,
// and freezes SW[7:0] while a handshake is in progress.
module switch_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned CNT_W           = 19
) (
    input  logic       Clock,
    input  logic       nReset,
    input  logic [8:0] SW_raw,
    output logic [8:0] SW_clean,
    output logic       SW8_rise,
    output logic       SW8_fall,
    output logic       busy
);

    typedef enum logic [1:0] {
        ST_LOW,
        ST_RISE_WAIT,
        ST_HIGH,
        ST_FALL_WAIT
    } state_e;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [8:0]       sync1_q, sync2_q;
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [8:0]       clean_q, clean_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_LOW: begin
                if (sync2_q[8]) begin
                    state_d = ST_RISE_WAIT;
                    cnt_d   = '0;
                end
            end
            ST_RISE_WAIT: begin
                if (!sync2_q[8])            state_d = ST_LOW;
                else if (cnt_q == CNT_LAST) state_d = ST_HIGH;
                else                        cnt_d   = cnt_q + CNT_W'(1);
            end
            ST_HIGH: begin
                if (!sync2_q[8]) begin
                    state_d = ST_FALL_WAIT;
                    cnt_d   = '0;
                end
            end
            ST_FALL_WAIT: begin
                if (sync2_q[8])             state_d = ST_HIGH;
                else if (cnt_q == CNT_LAST) state_d = ST_LOW;
                else                        cnt_d   = cnt_q + CNT_W'(1);
            end
            default: state_d = ST_LOW;
        endcase
    end

    // Data tracks only while idle LOW; the captured value is what the core loads on the handshake.
    always_comb begin
        clean_d[8]   = (state_d == ST_HIGH) || (state_d == ST_FALL_WAIT);
        clean_d[7:0] = (state_q == ST_LOW) ? sync2_q[7:0] : clean_q[7:0];
        rise_d       = (state_q == ST_RISE_WAIT) && (state_d == ST_HIGH);
        fall_d       = (state_q == ST_FALL_WAIT) && (state_d == ST_LOW);
    end

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            sync1_q <= '0;
            sync2_q <= '0;
            state_q <= ST_LOW;
            cnt_q   <= '0;
            clean_q <= '0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments let sync1/sync2 shift as a real two-flop chain.
            sync1_q <= SW_raw;
            sync2_q <= sync1_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            clean_q <= clean_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign SW_clean = clean_q;
    assign SW8_rise = rise_q;
    assign SW8_fall = fall_q;
    assign busy     = (state_q == ST_RISE_WAIT) || (state_q == ST_FALL_WAIT);

endmodule

// File: tb/tb_switch_conditioner.sv
// Bench for switch_conditioner: two instances (N=4 and N=1) checked every cycle against a
// run-length model of the debounce rule, plus directed literal checks at key edges.
module tb_switch_conditioner;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [8:0] raw   = 9'h1FF;

    logic [8:0] dut_clean [2];
    logic       dut_rise  [2];
    logic       dut_fall  [2];
    logic       dut_busy  [2];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    switch_conditioner #(.DEBOUNCE_CYCLES(4), .CNT_W(3)) u_n4 (
        .Clock(clk), .nReset(rst_n), .SW_raw(raw),
        .SW_clean(dut_clean[0]), .SW8_rise(dut_rise[0]), .SW8_fall(dut_fall[0]), .busy(dut_busy[0])
    );

    switch_conditioner #(.DEBOUNCE_CYCLES(1), .CNT_W(1)) u_n1 (
        .Clock(clk), .nReset(rst_n), .SW_raw(raw),
        .SW_clean(dut_clean[1]), .SW8_rise(dut_rise[1]), .SW8_fall(dut_fall[1]), .busy(dut_busy[1])
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: a level change is accepted once the synchronised input has disagreed with the
    // accepted level for DEBOUNCE_CYCLES+1 consecutive samples; data follows only when idle low.
    int         m_n    [2] = '{4, 1};
    logic [8:0] m_s1   [2] = '{9'h0, 9'h0};
    logic [8:0] m_s2   [2] = '{9'h0, 9'h0};
    logic       m_acc  [2] = '{1'b0, 1'b0};
    logic [7:0] m_data [2] = '{8'h0, 8'h0};
    int         m_run  [2] = '{0, 0};
    logic       m_rise [2] = '{1'b0, 1'b0};
    logic       m_fall [2] = '{1'b0, 1'b0};

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            for (int i = 0; i < 2; i++) begin
                if (!rst_n) begin
                    m_s1[i] = '0; m_s2[i] = '0; m_acc[i] = 1'b0; m_data[i] = '0;
                    m_run[i] = 0; m_rise[i] = 1'b0; m_fall[i] = 1'b0;
                end else begin
                    logic [8:0] s2_old;
                    s2_old  = m_s2[i];
                    m_s2[i] = m_s1[i];
                    m_s1[i] = raw;
                    if (!m_acc[i] && m_run[i] == 0) m_data[i] = s2_old[7:0];
                    m_rise[i] = 1'b0;
                    m_fall[i] = 1'b0;
                    if (s2_old[8] != m_acc[i]) begin
                        m_run[i]++;
                        if (m_run[i] == m_n[i] + 1) begin
                            m_acc[i]  = ~m_acc[i];
                            m_rise[i] = m_acc[i];
                            m_fall[i] = ~m_acc[i];
                            m_run[i]  = 0;
                        end
                    end else begin
                        m_run[i] = 0;
                    end
                end
            end
            #1;
            for (int i = 0; i < 2; i++) begin
                check($sformatf("model_clean[%0d]", i), 32'(dut_clean[i]), 32'({m_acc[i], m_data[i]}));
                check($sformatf("model_rise[%0d]", i), 32'(dut_rise[i]), 32'(m_rise[i]));
                check($sformatf("model_fall[%0d]", i), 32'(dut_fall[i]), 32'(m_fall[i]));
                check($sformatf("model_busy[%0d]", i), 32'(dut_busy[i]), 32'(m_run[i] > 0));
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive(input logic [8:0] v);
        @(negedge clk);
        raw = v;
    endtask

    initial begin
        // Reset held with all switches high: everything reads zero.
        step(3);
        check("rst_clean", 32'(dut_clean[0]), 32'h000);
        check("rst_rise", 32'(dut_rise[0]), 32'h0);
        check("rst_busy", 32'(dut_busy[0]), 32'h0);

        @(negedge clk);
        rst_n = 1'b1;
        step(2);
        check("rel_e2_data", 32'(dut_clean[0]), 32'h000);
        step(1);
        check("rel_e3_data", 32'(dut_clean[0]), 32'h0FF);
        check("n1_e3_clean8", 32'(dut_clean[1][8]), 32'h0);
        step(1);
        check("n1_e4_clean8", 32'(dut_clean[1][8]), 32'h1);
        check("n1_e4_rise", 32'(dut_rise[1]), 32'h1);
        step(2);
        check("rel_e6_clean8", 32'(dut_clean[0][8]), 32'h0);
        check("rel_e6_busy", 32'(dut_busy[0]), 32'h1);
        step(1);
        check("rel_e7_clean", 32'(dut_clean[0]), 32'h1FF);
        check("rel_e7_rise", 32'(dut_rise[0]), 32'h1);
        step(1);
        check("rel_e8_rise", 32'(dut_rise[0]), 32'h0);

        // Clean fall then clean rise with the busy window.
        drive(9'h0FF);
        step(6);
        check("fall_e6_clean8", 32'(dut_clean[0][8]), 32'h1);
        step(1);
        check("fall_e7_clean", 32'(dut_clean[0]), 32'h0FF);
        check("fall_e7_pulse", 32'(dut_fall[0]), 32'h1);
        step(1);
        check("fall_e8_pulse", 32'(dut_fall[0]), 32'h0);

        drive(9'h1FF);
        step(2);
        check("rise_e2_busy", 32'(dut_busy[0]), 32'h0);
        step(1);
        check("rise_e3_busy", 32'(dut_busy[0]), 32'h1);
        step(3);
        check("rise_e6_busy", 32'(dut_busy[0]), 32'h1);
        step(1);
        check("rise_e7_busy", 32'(dut_busy[0]), 32'h0);
        check("rise_e7_pulse", 32'(dut_rise[0]), 32'h1);
        drive(9'h000);
        step(9);

        // Glitch: three high samples are not enough for N=4.
        drive(9'h100);
        step(3);
        drive(9'h000);
        step(1);
        check("glitch_busy", 32'(dut_busy[0]), 32'h1);
        step(7);
        check("glitch_clean8", 32'(dut_clean[0][8]), 32'h0);
        check("glitch_idle", 32'(dut_busy[0]), 32'h0);

        // Bounce then steady high: one rise, 6 edges after the steady level is first sampled.
        drive(9'h100);
        drive(9'h000);
        drive(9'h100);
        drive(9'h000);
        drive(9'h100);
        step(6);
        check("bounce_e6_rise", 32'(dut_rise[0]), 32'h0);
        step(1);
        check("bounce_e7_rise", 32'(dut_rise[0]), 32'h1);
        check("bounce_e7_clean8", 32'(dut_clean[0][8]), 32'h1);

        // Data freeze across a full handshake.
        drive(9'h03C);
        step(9);
        check("freeze_idle", 32'(dut_clean[0]), 32'h03C);
        drive(9'h13C);
        step(8);
        check("freeze_high", 32'(dut_clean[0]), 32'h13C);
        drive(9'h1A5);
        step(4);
        check("freeze_hold", 32'(dut_clean[0]), 32'h13C);
        drive(9'h0A5);
        step(7);
        check("freeze_fall_e7", 32'(dut_clean[0]), 32'h03C);
        step(1);
        check("freeze_track_e8", 32'(dut_clean[0]), 32'h0A5);

        // Data change and handshake rise on the same raw edge: new data is captured.
        drive(9'h15A);
        step(3);
        check("simul_e3_data", 32'(dut_clean[0][7:0]), 32'h5A);
        drive(9'h1FF);
        step(8);
        check("simul_frozen", 32'(dut_clean[0]), 32'h15A);
        drive(9'h000);
        step(9);
        check("simul_released", 32'(dut_clean[0]), 32'h000);

        // Reset in the middle of a rise qualification (cnt == 2 after e5).
        drive(9'h100);
        step(5);
        #1 rst_n = 1'b0;
        #1;
        check("midrst_clean", 32'(dut_clean[0]), 32'h000);
        check("midrst_busy", 32'(dut_busy[0]), 32'h0);
        check("midrst_n1_clean", 32'(dut_clean[1]), 32'h000);
        @(negedge clk);
        rst_n = 1'b1;
        step(6);
        check("midrst_e6_clean8", 32'(dut_clean[0][8]), 32'h0);
        step(1);
        check("midrst_e7_rise", 32'(dut_rise[0]), 32'h1);
        check("midrst_e7_clean", 32'(dut_clean[0]), 32'h100);
        step(1);
        check("midrst_e8_rise", 32'(dut_rise[0]), 32'h0);

        step(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
